// File: rtl/dmem_responder.sv
// Data-memory responder: byte-laned RAM with lane-0 aligned load data, plus an
// optional MMIO window (64-bit timer, compare interrupt, GPIO) enabled by DMEM_MMIO_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic [2:0]  dmem_type,
    output logic [31:0] dmem_data,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        misalign_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [2:0]  T_B   = 3'b000;
    localparam logic [2:0]  T_H   = 3'b001;
    localparam logic [2:0]  T_W   = 3'b010;
    localparam logic [2:0]  T_BU  = 3'b100;
    localparam logic [2:0]  T_HU  = 3'b101;

    logic [31:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] ram_idx_s;
    logic [1:0]        byte_off_s;
    logic [31:0]       ram_word_s;
    logic [31:0]       ram_shift_s;
    logic              is_mmio_s;
    logic [31:0]       mmio_word_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_rep_s;
    logic              st_misalign_s;
    logic              st_active_s;
    logic              ram_we_s;
    logic              mmio_we_s;
    logic              misalign_err_r;
    logic              unused_s;

    assign ram_idx_s   = dmem_addr[ADDR_W+1:2];
    assign byte_off_s  = dmem_addr[1:0];
    assign ram_word_s  = mem_r[ram_idx_s];
    assign ram_shift_s = ram_word_s >> {byte_off_s, 3'b000};

    // Load path: RAM data shifted to lane 0; MMIO returns the whole register.
    always_comb begin
        dmem_data = ram_word_s;
        if (is_mmio_s) begin
            dmem_data = mmio_word_s;
        end else begin
            case (dmem_type)
                T_B, T_BU: dmem_data = ram_shift_s;
                T_H, T_HU: dmem_data = byte_off_s[0] ? 32'h0000_0000 : ram_shift_s;
                T_W:       dmem_data = (byte_off_s != 2'b00) ? 32'h0000_0000 : ram_word_s;
                default:   dmem_data = ram_word_s;
            endcase
        end
    end

    // Store decode: byte enables, lane replication and misalignment detection.
    always_comb begin
        be_s          = 4'b0000;
        wdata_rep_s   = dmem_wdata;
        st_misalign_s = 1'b0;
        case (dmem_type)
            T_B: begin
                be_s        = 4'b0001 << byte_off_s;
                wdata_rep_s = {4{dmem_wdata[7:0]}};
            end
            T_H: begin
                wdata_rep_s = {2{dmem_wdata[15:0]}};
                if (byte_off_s[0]) begin
                    st_misalign_s = 1'b1;
                end else begin
                    be_s = 4'b0011 << byte_off_s;
                end
            end
            T_W: begin
                if (byte_off_s != 2'b00) begin
                    st_misalign_s = 1'b1;
                end else begin
                    be_s = 4'b1111;
                end
            end
            default: be_s = 4'b0000;
        endcase
    end

    // A store in a reset cycle is dropped everywhere, RAM included.
    assign st_active_s = dmem_we & ~rst;
    assign ram_we_s    = st_active_s & ~is_mmio_s;
    assign mmio_we_s   = st_active_s & is_mmio_s & (dmem_type == T_W) & ~st_misalign_s;

    // RAM byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s && be_s[i]) begin
                mem_r[ram_idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
            end
        end
    end

    // Sticky misaligned-store flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_r <= 1'b0;
        end else if (dmem_we && st_misalign_s) begin
            misalign_err_r <= 1'b1;
        end
    end

    assign misalign_err = misalign_err_r;

`ifdef DMEM_MMIO_EN
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [31:0] gpio_r;
    logic        irq_r;
    logic [4:0]  mmio_off_s;

    assign is_mmio_s  = (dmem_addr[31:28] == MMIO_BASE[31:28]);
    assign mmio_off_s = dmem_addr[4:0];

    // MMIO read mux; unmapped offsets read zero.
    always_comb begin
        mmio_word_s = 32'h0000_0000;
        case (mmio_off_s)
            5'h00:   mmio_word_s = mtime_r[31:0];
            5'h04:   mmio_word_s = mtime_r[63:32];
            5'h08:   mmio_word_s = mtimecmp_r[31:0];
            5'h0C:   mmio_word_s = mtimecmp_r[63:32];
            5'h10:   mmio_word_s = gpio_r;
            default: mmio_word_s = 32'h0000_0000;
        endcase
    end

    // Free-running timer; a write to either half replaces the increment that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r <= 64'h0;
        end else if (mmio_we_s && (mmio_off_s == 5'h00)) begin
            mtime_r <= {mtime_r[63:32], dmem_wdata};
        end else if (mmio_we_s && (mmio_off_s == 5'h04)) begin
            mtime_r <= {dmem_wdata, mtime_r[31:0]};
        end else begin
            mtime_r <= mtime_r + 64'd1;
        end
    end

    // Compare register, GPIO and registered compare result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            gpio_r     <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            irq_r <= (mtime_r >= mtimecmp_r);
            if (mmio_we_s && (mmio_off_s == 5'h08)) begin
                mtimecmp_r[31:0] <= dmem_wdata;
            end
            if (mmio_we_s && (mmio_off_s == 5'h0C)) begin
                mtimecmp_r[63:32] <= dmem_wdata;
            end
            if (mmio_we_s && (mmio_off_s == 5'h10)) begin
                gpio_r <= dmem_wdata;
            end
        end
    end

    assign gpio_out  = gpio_r;
    assign timer_irq = irq_r;
`else
    assign is_mmio_s   = 1'b0;
    assign mmio_word_s = 32'h0000_0000;
    assign gpio_out    = 32'h0000_0000;
    assign timer_irq   = 1'b0;
`endif

    // Address bits above the RAM index are deliberately ignored (aliasing).
    assign unused_s = ^{dmem_addr, MMIO_BASE, mmio_we_s};

endmodule
